// File: rtl/slider_key_ctrl.sv
// rtl/slider_key_ctrl.sv - key synchronizer, debounce and axis arbitration for the slider stage
module slider_key_ctrl #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int CNT_W           = 4
) (
    input  logic       iFrame_CLK,
    input  logic       iRST_n,
    input  logic [3:0] iKEY,
    input  logic       iEnable,
    output logic       oSlider_go,
    output logic       oSlider_back,
    output logic       oSlider_up,
    output logic       oSlider_down,
    output logic [3:0] oKey_pulse
);

    typedef enum logic [1:0] {RELEASED, PRESS_CNT, PRESSED, RELEASE_CNT} key_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       sync1, sync2, deb, deb_d, rise;
    key_state_t       state [4];
    key_state_t       state_next [4];
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_next [4];
    owner_t           own_x, own_y, own_x_next, own_y_next;

    // Last-pressed-wins; a simultaneous press locks the axis out until one key lets go.
    function automatic owner_t arbitrate(owner_t cur, logic deb_a, logic deb_b,
                                         logic rise_a, logic rise_b);
        owner_t nxt;
        nxt = cur;
        if (deb_a && deb_b) begin
            if (rise_a && rise_b)  nxt = OWN_NONE;
            else if (rise_a)       nxt = OWN_A;
            else if (rise_b)       nxt = OWN_B;
        end else if (deb_a) begin
            nxt = OWN_A;
        end else if (deb_b) begin
            nxt = OWN_B;
        end else begin
            nxt = OWN_NONE;
        end
        return nxt;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                RELEASED: if (sync2[i]) begin
                    state_next[i] = PRESS_CNT;
                    cnt_next[i]   = CNT_ONE;
                end
                PRESS_CNT: begin
                    if (!sync2[i])              state_next[i] = RELEASED;
                    else if (cnt[i] == CNT_LAST) state_next[i] = PRESSED;
                    else                        cnt_next[i]   = cnt[i] + CNT_ONE;
                end
                PRESSED: if (!sync2[i]) begin
                    state_next[i] = RELEASE_CNT;
                    cnt_next[i]   = CNT_ONE;
                end
                RELEASE_CNT: begin
                    if (sync2[i])               state_next[i] = PRESSED;
                    else if (cnt[i] == CNT_LAST) state_next[i] = RELEASED;
                    else                        cnt_next[i]   = cnt[i] + CNT_ONE;
                end
                default: state_next[i] = RELEASED;
            endcase
            deb[i] = (state[i] == PRESSED) || (state[i] == RELEASE_CNT);
        end
        rise       = deb & ~deb_d;
        own_x_next = arbitrate(own_x, deb[0], deb[1], rise[0], rise[1]);
        own_y_next = arbitrate(own_y, deb[2], deb[3], rise[2], rise[3]);
    end

    always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1        <= '0;
            sync2        <= '0;
            deb_d        <= '0;
            own_x        <= OWN_NONE;
            own_y        <= OWN_NONE;
            oSlider_go   <= 1'b0;
            oSlider_back <= 1'b0;
            oSlider_up   <= 1'b0;
            oSlider_down <= 1'b0;
            oKey_pulse   <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
        end else begin
            sync1        <= ~iKEY;
            sync2        <= sync1;
            deb_d        <= deb;
            own_x        <= own_x_next;
            own_y        <= own_y_next;
            oSlider_go   <= iEnable && (own_x_next == OWN_A);
            oSlider_back <= iEnable && (own_x_next == OWN_B);
            oSlider_up   <= iEnable && (own_y_next == OWN_A);
            oSlider_down <= iEnable && (own_y_next == OWN_B);
            oKey_pulse   <= {4{iEnable}} & rise;
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_slider_key_ctrl.sv
// tb/tb_slider_key_ctrl.sv - randomized and directed bench for slider_key_ctrl against a run-length model
module tb_slider_key_ctrl;

    localparam int DF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic       en = 1'b1;
    logic       go, back, up, down;
    logic [3:0] pulse;

    int errors = 0;
    int checks = 0;

    // Model: per key, a debounced level flips once DF consecutive synchronized
    // samples disagree with it; any agreeing sample restarts the run.
    logic [3:0] m_s1, m_s2, m_deb, m_deb_d, m_pulse;
    int         m_run [4];
    int         m_own [2];   // 0 none, 1 first key of pair, 2 second key
    logic [3:0] m_slider;    // {go, back, up, down}

    slider_key_ctrl #(.DEBOUNCE_FRAMES(DF), .CNT_W(4)) dut (
        .iFrame_CLK  (clk),
        .iRST_n      (rst_n),
        .iKEY        (key),
        .iEnable     (en),
        .oSlider_go  (go),
        .oSlider_back(back),
        .oSlider_up  (up),
        .oSlider_down(down),
        .oKey_pulse  (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_d = 0; m_pulse = 0; m_slider = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_own[0] = 0; m_own[1] = 0;
    endtask

    function automatic int pick_owner(int cur, logic a, logic b, logic ra, logic rb);
        if (a && b) begin
            if (ra && rb) return 0;
            if (ra) return 1;
            if (rb) return 2;
            return cur;
        end
        if (a) return 1;
        if (b) return 2;
        return 0;
    endfunction

    task automatic model_edge();
        logic [3:0] r;
        r = m_deb & ~m_deb_d;
        m_own[0] = pick_owner(m_own[0], m_deb[0], m_deb[1], r[0], r[1]);
        m_own[1] = pick_owner(m_own[1], m_deb[2], m_deb[3], r[2], r[3]);
        m_slider = {en && m_own[0] == 1, en && m_own[0] == 2, en && m_own[1] == 1, en && m_own[1] == 2};
        m_pulse  = en ? r : 4'h0;
        m_deb_d  = m_deb;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DF) begin
                    m_deb[i] = ~m_deb[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = ~key;
    endtask

    // Drive inputs, advance one edge, then compare against the model at the falling edge.
    task automatic step(input logic [3:0] k, input logic e);
        key = k;
        en  = e;
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        check("model_slider", {4'h0, go, back, up, down}, {4'h0, m_slider});
        check("model_pulse", {4'h0, pulse}, {4'h0, m_pulse});
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 1'b1);
    endtask

    logic [3:0] rk;
    logic       re;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_out", {3'b0, go, back, up, down, 1'b0}, 8'h00);
        check("reset_pulse", {4'h0, pulse}, 8'h00);
        rst_n = 1'b1;

        // Single press latency and one-frame strobe
        for (int k = 1; k <= 8; k++) begin
            step(4'b1110, 1'b1);
            check($sformatf("go_lat_e%0d", k), {7'h0, go}, {7'h0, k >= 6});
            check($sformatf("go_pulse_e%0d", k), {4'h0, pulse}, (k == 6) ? 8'h01 : 8'h00);
        end
        settle(10);

        // Two-frame glitch on up is swallowed
        step(4'b1011, 1'b1);
        step(4'b1011, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'hF, 1'b1);
            check("glitch_up", {6'h0, up, pulse[2]}, 8'h00);
        end

        // Go held, back pressed later takes over, release hands back to go
        for (int k = 0; k < 16; k++) step(4'b1110, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step(4'b1100, 1'b1);
            check($sformatf("takeover_e%0d", k), {6'h0, go, back}, (k >= 6) ? 8'h01 : 8'h02);
        end
        for (int k = 1; k <= 7; k++) begin
            step(4'b1110, 1'b1);
            check($sformatf("handback_e%0d", k), {6'h0, go, back}, (k >= 6) ? 8'h02 : 8'h01);
        end
        settle(10);

        // Simultaneous press locks axis to none
        for (int k = 1; k <= 12; k++) begin
            step(4'b1100, 1'b1);
            check($sformatf("simul_pulse_e%0d", k), {4'h0, pulse}, (k == 6) ? 8'h03 : 8'h00);
            check("simul_none", {6'h0, go, back}, 8'h00);
        end
        for (int k = 1; k <= 7; k++) begin
            step(4'b1110, 1'b1);
            check($sformatf("simul_rel_e%0d", k), {6'h0, go, back}, (k >= 6) ? 8'h02 : 8'h00);
        end
        settle(10);

        // Enable gating
        for (int k = 0; k < 10; k++) step(4'b0111, 1'b1);
        check("down_held", {7'h0, down}, 8'h01);
        for (int k = 0; k < 4; k++) begin
            step(4'b0111, 1'b0);
            check("en_off", {3'h0, down, pulse}, 8'h00);
        end
        step(4'b0111, 1'b1);
        check("en_on", {3'h0, down, pulse}, 8'h10);
        settle(10);

        // Reset mid-debounce while up is held
        for (int k = 0; k < 3; k++) step(4'b1011, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async", {3'h0, go | back | up | down, pulse}, 8'h00);
        step(4'b1011, 1'b1);
        step(4'b1011, 1'b1);
        check("rst_hold", {3'h0, go | back | up | down, pulse}, 8'h00);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(4'b1011, 1'b1);
            check($sformatf("rst_up_e%0d", k), {7'h0, up}, {7'h0, k >= 6});
        end

        // Random phase
        rk = 4'hF;
        re = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rk[b] = ~rk[b];
            if ($urandom_range(0, 31) == 0) re = ~re;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rnd_rst", {3'h0, go | back | up | down, pulse}, 8'h00);
                step(rk, re);
                rst_n = 1'b1;
            end
            step(rk, re);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slider_key_ctrl.md
Name: slider_key_ctrl

Overview:
Upstream conditioner for the slider position stage. It samples the four raw active-low push keys once per frame and produces clean, level-held direction commands (go/back/up/down) that the slider stage consumes directly.
Per key: a two-flop synchronizer and a debounce state machine. Per axis: an arbiter that resolves opposing keys held together. The block also emits one-frame press strobes for menu/game logic.

Parameters:
DEBOUNCE_FRAMES, 3, consecutive identical synchronized samples required to change a debounced level; legal range 2..15
CNT_W, 4, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_FRAMES

Ports:
iFrame_CLK  input  1  frame-rate clock, the only clock
iRST_n  input  1  asynchronous active-low reset
iKEY  input  4  raw keys, active-low, asynchronous; bit0 go, bit1 back, bit2 up, bit3 down
iEnable  input  1  high = game running; low forces all outputs to 0
oSlider_go  output  1  registered level, move +x
oSlider_back  output  1  registered level, move -x
oSlider_up  output  1  registered level, move -y
oSlider_down  output  1  registered level, move +y
oKey_pulse  output  4  one-frame strobe on each debounced press, same bit order as iKEY

Behaviour:
Clock and reset:
- Single clock iFrame_CLK; reset is asynchronous and active-low on iRST_n.
- Reset values: synchronizer flops 0; all key FSMs in RELEASED with counter 0; both axis owners NONE; all outputs 0.
- Reset asserted mid-debounce aborts the debounce. A key still held when reset releases is treated as a new press and requires a full debounce.

Synchronizer:
- Per bit, s1 <= ~iKEY[i], then s2 <= s1.
- The FSM sees s2.

Key FSM (per bit), states RELEASED, PRESS_CNT, PRESSED, RELEASE_CNT:
- RELEASED: s2=1 -> PRESS_CNT, cnt=1; else stay.
- PRESS_CNT: s2=0 -> RELEASED. s2=1 and cnt==DEBOUNCE_FRAMES-1 -> PRESSED. Otherwise cnt+1.
- PRESSED: s2=0 -> RELEASE_CNT, cnt=1; else stay.
- RELEASE_CNT: s2=1 -> PRESSED. s2=0 and cnt==DEBOUNCE_FRAMES-1 -> RELEASED. Otherwise cnt+1.
- Debounced level deb[i] = 1 in PRESSED or RELEASE_CNT.
- A glitch shorter than DEBOUNCE_FRAMES samples never changes deb.
- rise[i] = deb[i] & ~deb_d[i], where deb_d is deb delayed one frame.

Axis arbiter (pairs go/back and up/down), owner register in {NONE, A, B}:
- Only one key of the pair debounced -> owner = that key.
- Neither debounced -> owner = NONE.
- Both debounced and exactly one rose this frame -> owner = the one that rose (last pressed wins).
- Both rise in the same frame -> owner = NONE. It stays NONE while both are held, until one releases.
- Both held, no rise -> owner unchanged.

Outputs (registered, updated at the edge after deb/owner are computed):
- oSlider_go <= iEnable & (owner_x==A); same rule for back, up and down.
- oKey_pulse[i] <= iEnable & rise[i]. Strobes are independent of arbitration.
- iEnable low: outputs are 0 on the next edge; FSMs and arbiters keep running.

Latency:
- Counting the first edge at which iKEY[i] is sampled low as edge 1, deb rises at edge DEBOUNCE_FRAMES+2.
- oSlider_*/oKey_pulse rise at edge DEBOUNCE_FRAMES+3 (6 for the default).
- Release latency is symmetric.

Test Plan:
- Reset with iKEY=4'hF, then hold iKEY[0]=0 from edge 1, iEnable=1 -> oSlider_go=0 through edge 5, =1 after edge 6; oKey_pulse=4'b0001 for exactly the frame after edge 6.
- iKEY[2] low for 2 frames, then high -> oSlider_up and oKey_pulse[2] never assert; FSM returns to RELEASED.
- Hold go, debounced; press back 10 frames later -> oSlider_go falls and oSlider_back rises 6 frames after back is pressed; release back -> go reasserts 6 frames after the release.
- iKEY[1:0] both driven low at the same edge -> both pulse bits fire together, oSlider_go=oSlider_back=0 while both are held; release back -> oSlider_go=1 after the release latency.
- Hold down, debounced, then drop iEnable for 4 frames -> oSlider_down=0 on the next edge, no pulses; raise iEnable -> oSlider_down=1 next edge with no new pulse.
- Assert iRST_n=0 mid PRESS_CNT while holding up, release reset with the key still held -> all outputs 0 during reset; oSlider_up rises 6 edges after reset release.
